branch_pred_sat_table: RTL and testbench

Parametrised branch-history table of saturating counters that generalises the one-bit predictor to `2^INDEX_W` entries of `CTR_W`-bit counters. It has separate predict and resolve ports and a global outcome-history register. It also keeps a running mispredict count. The block sits beside the fetch model in the branch-predictor test environment and is driven by the trace-replay bench.

---
 rtl/branch_pred_sat_table.sv | 112 +++++++++++
 tb/tb_branch_pred_sat_table.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_sat_table.sv
// branch_pred_sat_table: 2^INDEX_W saturating-counter branch-history table
// with a registered predict port, a resolve/update port, a global outcome
// history register and a saturating mispredict counter.
// Optional feature: define BRANCH_PRED_GSHARE_EN to index the table with
// (index XOR history) instead of the raw index.
module branch_pred_sat_table #(
   parameter int unsigned INDEX_W = 4,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned HIST_W  = 8,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pred_valid,
   input  logic [INDEX_W-1:0] pred_index,
   output logic               pred_out_valid,
   output logic               pred_taken,
   input  logic               upd_valid,
   input  logic [INDEX_W-1:0] upd_index,
   input  logic               upd_taken,
   output logic [HIST_W-1:0]  branch_history,
   output logic [CNT_W-1:0]   mispredict_cnt
);

   localparam int unsigned     ENTRIES  = 1 << INDEX_W;
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [CTR_W-1:0]   r_table [ENTRIES];
   logic               r_pred_valid;
   logic               r_pred_taken;
   logic [HIST_W-1:0]  r_hist;
   logic [CNT_W-1:0]   r_mis_cnt;

   logic [INDEX_W-1:0] w_pred_idx;
   logic [INDEX_W-1:0] w_upd_idx;
   logic [CTR_W-1:0]   w_upd_ctr;
   logic [CTR_W-1:0]   w_upd_next;
   logic               w_mispred;
   logic [HIST_W-1:0]  w_hist_next;

`ifdef BRANCH_PRED_GSHARE_EN
   // History folded to index width (zero-extended or truncated) for gshare hashing.
   logic [INDEX_W-1:0] w_hist_idx;
   assign w_hist_idx = INDEX_W'(r_hist);
   assign w_pred_idx = pred_index ^ w_hist_idx;
   assign w_upd_idx  = upd_index ^ w_hist_idx;
`else
   assign w_pred_idx = pred_index;
   assign w_upd_idx  = upd_index;
`endif

   // Next history value: shift in the newest outcome at bit 0.
   generate
      if (HIST_W == 1) begin : g_hist1
         assign w_hist_next = upd_taken;
      end else begin : g_histn
         assign w_hist_next = {r_hist[HIST_W-2:0], upd_taken};
      end
   endgenerate

   assign w_upd_ctr = r_table[w_upd_idx];
   assign w_mispred = (w_upd_ctr[CTR_W-1] != upd_taken);

   // Saturating increment/decrement of the resolved entry.
   always_comb begin
      w_upd_next = w_upd_ctr;
      if (upd_taken) begin
         if (w_upd_ctr != CTR_MAX) w_upd_next = w_upd_ctr + CTR_W'(1);
      end else begin
         if (w_upd_ctr != '0) w_upd_next = w_upd_ctr - CTR_W'(1);
      end
   end

   // Counter table; written only on a resolved branch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) r_table[i] <= CTR_INIT;
      end else if (upd_valid) begin
         r_table[w_upd_idx] <= w_upd_next;
      end
   end

   // Prediction read register; reads the pre-update table contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
      end else begin
         r_pred_valid <= pred_valid;
         if (pred_valid) r_pred_taken <= r_table[w_pred_idx][CTR_W-1];
      end
   end

   // Global history and saturating mispredict count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist    <= '0;
         r_mis_cnt <= '0;
      end else if (upd_valid) begin
         r_hist <= w_hist_next;
         if (w_mispred && (r_mis_cnt != CNT_MAX)) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
   end

   assign pred_out_valid = r_pred_valid;
   assign pred_taken     = r_pred_taken;
   assign branch_history = r_hist;
   assign mispredict_cnt = r_mis_cnt;

endmodule

// File: tb/tb_branch_pred_sat_table.sv
// Bench for branch_pred_sat_table: two instances (default build and a
// CTR_W=1/HIST_W=1/CNT_W=2 build) share one stimulus stream and are checked
// every cycle against an arithmetic model, plus literal spot checks.
module tb_branch_pred_sat_table;

   logic       clk = 1'b0;
   logic       rst;
   logic       pred_valid;
   logic [3:0] pred_index;
   logic       upd_valid;
   logic [3:0] upd_index;
   logic       upd_taken;

   logic        a_pov, a_ptk;
   logic [7:0]  a_hist;
   logic [15:0] a_cnt;
   logic        b_pov, b_ptk;
   logic [0:0]  b_hist;
   logic [1:0]  b_cnt;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model configuration per instance: index, counter, history, count widths.
   localparam int IW [2] = '{4, 3};
   localparam int CW [2] = '{2, 1};
   localparam int HW [2] = '{8, 1};
   localparam int NW [2] = '{16, 2};

   int m_tab [2][16];
   int m_hist [2];
   int m_cnt [2];
   int m_pov [2];
   int m_ptk [2];

   always #5 clk = ~clk;

   branch_pred_sat_table u_dut_a (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_index(pred_index),
      .pred_out_valid(a_pov), .pred_taken(a_ptk),
      .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
      .branch_history(a_hist), .mispredict_cnt(a_cnt)
   );

   branch_pred_sat_table #(.INDEX_W(3), .CTR_W(1), .HIST_W(1), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_index(pred_index[2:0]),
      .pred_out_valid(b_pov), .pred_taken(b_ptk),
      .upd_valid(upd_valid), .upd_index(upd_index[2:0]), .upd_taken(upd_taken),
      .branch_history(b_hist), .mispredict_cnt(b_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int e = 0; e < 16; e++) m_tab[m][e] = (1 << (CW[m] - 1)) - 1;
         m_hist[m] = 0;
         m_cnt[m]  = 0;
         m_pov[m]  = 0;
         m_ptk[m]  = 0;
      end
   endtask

   // One accepted clock edge: predictions read the old state, then the update applies.
   task automatic model_step(input int pv, input int pi, input int uv, input int ui, input int ut);
      for (int m = 0; m < 2; m++) begin
         int imask, half, top, pidx, uidx, c;
         imask = (1 << IW[m]) - 1;
         half  = 1 << (CW[m] - 1);
         top   = (1 << CW[m]) - 1;
         pidx  = pi & imask;
         uidx  = ui & imask;
`ifdef BRANCH_PRED_GSHARE_EN
         pidx = pidx ^ (m_hist[m] & imask);
         uidx = uidx ^ (m_hist[m] & imask);
`endif
         m_pov[m] = pv;
         if (pv != 0) m_ptk[m] = (m_tab[m][pidx] >= half) ? 1 : 0;
         if (uv != 0) begin
            c = m_tab[m][uidx];
            if ((c >= half) != (ut != 0))
               m_cnt[m] = (m_cnt[m] < (1 << NW[m]) - 1) ? m_cnt[m] + 1 : m_cnt[m];
            if (ut != 0) m_tab[m][uidx] = (c < top) ? c + 1 : c;
            else         m_tab[m][uidx] = (c > 0) ? c - 1 : 0;
            m_hist[m] = ((m_hist[m] << 1) | ut) & ((1 << HW[m]) - 1);
         end
      end
   endtask

   // Drive one cycle of stimulus; returns at the following falling edge.
   task automatic cyc(input int pv, input int pi, input int uv, input int ui, input int ut);
      pred_valid = 1'(pv);
      pred_index = 4'(pi);
      upd_valid  = 1'(uv);
      upd_index  = 4'(ui);
      upd_taken  = 1'(ut);
      @(posedge clk);
      if (!rst) model_step(pv, pi, uv, ui, ut);
      @(negedge clk);
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("a.pred_out_valid", 32'(a_pov), 32'(m_pov[0]));
         check("a.pred_taken", 32'(a_ptk), 32'(m_ptk[0]));
         check("a.branch_history", 32'(a_hist), 32'(m_hist[0]));
         check("a.mispredict_cnt", 32'(a_cnt), 32'(m_cnt[0]));
         check("b.pred_out_valid", 32'(b_pov), 32'(m_pov[1]));
         check("b.pred_taken", 32'(b_ptk), 32'(m_ptk[1]));
         check("b.branch_history", 32'(b_hist), 32'(m_hist[1]));
         check("b.mispredict_cnt", 32'(b_cnt), 32'(m_cnt[1]));
      end
   end

   initial begin
      rst = 1'b1;
      pred_valid = 1'b0; pred_index = '0;
      upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;
      model_reset();
      #1;
      check("reset.a_pov", 32'(a_pov), 0);
      check("reset.a_ptk", 32'(a_ptk), 0);
      check("reset.a_hist", 32'(a_hist), 0);
      check("reset.a_cnt", 32'(a_cnt), 0);
      check("reset.b_cnt", 32'(b_cnt), 0);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

`ifndef BRANCH_PRED_GSHARE_EN
      // Reset-state prediction on index 3.
      cyc(1, 3, 0, 0, 0);
      check("lit.idx3_pov", 32'(a_pov), 1);
      check("lit.idx3_ptk", 32'(a_ptk), 0);
      check("lit.idx3_cnt", 32'(a_cnt), 0);
      cyc(0, 0, 0, 0, 0);
      check("lit.idle_pov", 32'(a_pov), 0);

      // Saturate index 5 upward, then walk it back down.
      repeat (3) cyc(0, 0, 1, 5, 1);
      cyc(1, 5, 0, 0, 0);
      check("lit.sat_ptk", 32'(a_ptk), 1);
      check("lit.sat_cnt", 32'(a_cnt), 1);
      check("lit.sat_hist", 32'(a_hist), 32'h07);
      repeat (2) cyc(0, 0, 1, 5, 0);
      cyc(1, 5, 0, 0, 0);
      check("lit.down_ptk", 32'(a_ptk), 0);
      check("lit.down_cnt", 32'(a_cnt), 3);
      check("lit.down_hist", 32'(a_hist), 32'h1C);

      // Same-cycle predict and update on index 2 reads the old entry.
      cyc(1, 2, 1, 2, 1);
      check("lit.rbw_ptk", 32'(a_ptk), 0);
      check("lit.rbw_cnt", 32'(a_cnt), 4);
      cyc(1, 2, 0, 0, 0);
      check("lit.after_ptk", 32'(a_ptk), 1);

      // Alternating outcomes on index 0.
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 1, 0, 0);
      check("lit.alt_hist", 32'(a_hist[3:0]), 32'hA);
      check("lit.alt_cnt", 32'(a_cnt), 8);
      check("lit.b_cnt_sat", 32'(b_cnt), 3);
      check("lit.b_hist", 32'(b_hist), 0);
`endif

      // Mixed traffic, model-checked every cycle.
      for (int i = 0; i < 24; i++)
         cyc((i % 3 != 0) ? 1 : 0, (i * 5) & 15, (i % 2 == 0) ? 1 : 0, (i * 3) & 15, (i >> 1) & 1);

      // Reset mid-stream with a prediction in flight.
      pred_valid = 1'b1; pred_index = 4'd5;
      upd_valid = 1'b1; upd_index = 4'd6; upd_taken = 1'b1;
      @(posedge clk);
      model_step(1, 5, 1, 6, 1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("midrst.a_pov", 32'(a_pov), 0);
      check("midrst.a_ptk", 32'(a_ptk), 0);
      check("midrst.a_hist", 32'(a_hist), 0);
      check("midrst.a_cnt", 32'(a_cnt), 0);
      check("midrst.b_cnt", 32'(b_cnt), 0);
      @(negedge clk);
      cyc(1, 5, 1, 5, 1);
      cyc(1, 5, 1, 5, 1);
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0);
      check("midrst.no_pulse", 32'(a_pov), 0);
      cyc(1, 5, 0, 0, 0);
      check("midrst.pred_pov", 32'(a_pov), 1);
      check("midrst.pred_ptk", 32'(a_ptk), 0);
      cyc(0, 0, 0, 0, 0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
